// File: rtl/phimap_term_sequencer_if.sv
// Handshake bundle for the phi-map term sequencer: sample input, phi-map datapath
// link and serialized term output.
interface phimap_term_sequencer_if #(
    parameter int Q_ORD     = 3,
    parameter int WIDTH     = 16,
    parameter int LOG_WIDTH = 17
);
    localparam int IDX_W = (Q_ORD > 1) ? $clog2(Q_ORD) : 1;

    logic signed [WIDTH-1:0]     in_x;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [WIDTH-1:0]     map_x;
    logic [Q_ORD*LOG_WIDTH-1:0]  map_log_packed;
    logic [Q_ORD-1:0]            map_sign_packed;
    logic [Q_ORD-1:0]            map_valid_packed;
    logic [LOG_WIDTH-1:0]        out_log;
    logic                        out_sign;
    logic                        out_zero;
    logic                        out_last;
    logic [IDX_W-1:0]            out_idx;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;

    modport master (
        output in_x, in_valid, map_log_packed, map_sign_packed, map_valid_packed, out_ready,
        input  in_ready, map_x, out_log, out_sign, out_zero, out_last, out_idx, out_valid, busy
    );

    modport slave (
        input  in_x, in_valid, map_log_packed, map_sign_packed, map_valid_packed, out_ready,
        output in_ready, map_x, out_log, out_sign, out_zero, out_last, out_idx, out_valid, busy
    );
endinterface

// File: rtl/phimap_term_sequencer.sv
// Latches one sample, captures its Q_ORD phi-map log terms in a single MAP cycle and
// serializes them over a valid/ready term stream. All outputs come straight from flops.
module phimap_term_sequencer #(
    parameter int Q_ORD     = 3,
    parameter int WIDTH     = 16,
    parameter int LOG_WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    phimap_term_sequencer_if.slave   bus
);
    localparam int IDX_W = (Q_ORD > 1) ? $clog2(Q_ORD) : 1;
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(Q_ORD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAP  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t                      state_r,   state_nxt_s;
    logic [IDX_W-1:0]            idx_r,     idx_nxt_s;
    logic signed [WIDTH-1:0]     x_r,       x_nxt_s;
    logic [Q_ORD*LOG_WIDTH-1:0]  log_r,     log_nxt_s;
    logic [Q_ORD-1:0]            sign_r,    sign_nxt_s;
    logic [Q_ORD-1:0]            tvalid_r,  tvalid_nxt_s;

    logic                        in_ready_r,  in_ready_nxt_s;
    logic                        busy_r,      busy_nxt_s;
    logic                        out_valid_r, out_valid_nxt_s;
    logic [LOG_WIDTH-1:0]        out_log_r,   out_log_nxt_s;
    logic                        out_sign_r,  out_sign_nxt_s;
    logic                        out_zero_r,  out_zero_nxt_s;
    logic                        out_last_r,  out_last_nxt_s;
    logic [IDX_W-1:0]            out_idx_r,   out_idx_nxt_s;

    // Next-state, sample latch and term capture; map_* is only looked at in ST_MAP.
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        x_nxt_s      = x_r;
        log_nxt_s    = log_r;
        sign_nxt_s   = sign_r;
        tvalid_nxt_s = tvalid_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    x_nxt_s     = bus.in_x;
                    state_nxt_s = ST_MAP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MAP: begin
                log_nxt_s    = bus.map_log_packed;
                sign_nxt_s   = bus.map_sign_packed;
                tvalid_nxt_s = bus.map_valid_packed;
                idx_nxt_s    = IDX_ZERO;
                state_nxt_s  = ST_EMIT;
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    if (idx_r == IDX_LAST) begin
                        idx_nxt_s   = IDX_ZERO;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                idx_nxt_s   = IDX_ZERO;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state so they can be registered.
    always_comb begin
        in_ready_nxt_s  = (state_nxt_s == ST_IDLE);
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        out_valid_nxt_s = 1'b0;
        out_log_nxt_s   = {LOG_WIDTH{1'b0}};
        out_sign_nxt_s  = 1'b0;
        out_zero_nxt_s  = 1'b0;
        out_last_nxt_s  = 1'b0;
        out_idx_nxt_s   = IDX_ZERO;
        if (state_nxt_s == ST_EMIT) begin
            out_valid_nxt_s = 1'b1;
            out_last_nxt_s  = (idx_nxt_s == IDX_LAST);
            out_idx_nxt_s   = idx_nxt_s;
            for (int k = 0; k < Q_ORD; k++) begin
                if (idx_nxt_s == IDX_W'(k)) begin
                    out_log_nxt_s  = log_nxt_s[k*LOG_WIDTH +: LOG_WIDTH];
                    out_sign_nxt_s = sign_nxt_s[k];
                    out_zero_nxt_s = ~tvalid_nxt_s[k];
                end else begin
                    out_log_nxt_s  = out_log_nxt_s;
                end
            end
        end else begin
            out_valid_nxt_s = 1'b0;
        end
    end

    // State, term storage and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= IDX_ZERO;
            x_r         <= {WIDTH{1'b0}};
            log_r       <= {(Q_ORD*LOG_WIDTH){1'b0}};
            sign_r      <= {Q_ORD{1'b0}};
            tvalid_r    <= {Q_ORD{1'b0}};
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_log_r   <= {LOG_WIDTH{1'b0}};
            out_sign_r  <= 1'b0;
            out_zero_r  <= 1'b0;
            out_last_r  <= 1'b0;
            out_idx_r   <= IDX_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            x_r         <= x_nxt_s;
            log_r       <= log_nxt_s;
            sign_r      <= sign_nxt_s;
            tvalid_r    <= tvalid_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            busy_r      <= busy_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_log_r   <= out_log_nxt_s;
            out_sign_r  <= out_sign_nxt_s;
            out_zero_r  <= out_zero_nxt_s;
            out_last_r  <= out_last_nxt_s;
            out_idx_r   <= out_idx_nxt_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.map_x     = x_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_log   = out_log_r;
    assign bus.out_sign  = out_sign_r;
    assign bus.out_zero  = out_zero_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_idx   = out_idx_r;
endmodule

// File: tb/tb_phimap_term_sequencer.sv
// Bench for phimap_term_sequencer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_phimap_term_sequencer;
    localparam int Q  = 3;
    localparam int W  = 16;
    localparam int LW = 17;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    phimap_term_sequencer_if #(.Q_ORD(Q), .WIDTH(W), .LOG_WIDTH(LW)) bus ();

    phimap_term_sequencer #(.Q_ORD(Q), .WIDTH(W), .LOG_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [LW-1:0] lg;
        logic          s;
        logic          z;
        int            idx;
    } term_t;

    term_t             q_m[$];
    bit                map_pend_m = 1'b0;
    logic signed [W-1:0] x_m = '0;
    bit                chk_en = 1'b0;
    int                n_total = 0;
    int                n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: at each negedge compare, then advance using the inputs the next edge will see.
    always @(negedge clk) begin
        term_t t;
        if (chk_en) begin
            if (q_m.size() != 0) t = q_m[0];
            else begin t.lg = '0; t.s = 1'b0; t.z = 1'b0; t.idx = 0; end
            chk("in_ready",  bus.in_ready,  (!map_pend_m && q_m.size() == 0));
            chk("busy",      bus.busy,      (map_pend_m || q_m.size() != 0));
            chk("out_valid", bus.out_valid, (q_m.size() != 0));
            chk("map_x",     bus.map_x,     x_m);
            chk("out_log",   bus.out_log,   t.lg);
            chk("out_sign",  bus.out_sign,  t.s);
            chk("out_zero",  bus.out_zero,  t.z);
            chk("out_idx",   bus.out_idx,   t.idx);
            chk("out_last",  bus.out_last,  (q_m.size() != 0 && t.idx == Q - 1));
        end
        if (reset) begin
            q_m.delete();
            map_pend_m = 1'b0;
            x_m = '0;
        end else if (map_pend_m) begin
            for (int k = 0; k < Q; k++) begin
                term_t n;
                n.lg  = bus.map_log_packed[k*LW +: LW];
                n.s   = bus.map_sign_packed[k];
                n.z   = !bus.map_valid_packed[k];
                n.idx = k;
                q_m.push_back(n);
            end
            map_pend_m = 1'b0;
        end else if (q_m.size() != 0) begin
            if (bus.out_ready) void'(q_m.pop_front());
        end else if (bus.in_valid) begin
            x_m = bus.in_x;
            map_pend_m = 1'b1;
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.in_x = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.map_log_packed = '0; bus.map_sign_packed = '0; bus.map_valid_packed = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_map_x", bus.map_x, 16'h0000);

        // Basic sample
        drive_edge();
        bus.in_x = 16'h1000; bus.in_valid = 1'b1;
        bus.map_log_packed = {17'h00100, 17'h1F000, 17'h00010};
        bus.map_sign_packed = 3'b010; bus.map_valid_packed = 3'b111;
        @(negedge clk); chk("basic_accept_ready", bus.in_ready, 1'b1);
        drive_edge(); bus.in_valid = 1'b0;
        @(negedge clk); chk("basic_map_x", bus.map_x, 16'h1000); chk("basic_map_nv", bus.out_valid, 1'b0);
        @(negedge clk); chk("basic_t0_log", bus.out_log, 17'h00010); chk("basic_t0_sign", bus.out_sign, 1'b0);
        chk("basic_t0_last", bus.out_last, 1'b0); chk("basic_t0_valid", bus.out_valid, 1'b1);
        @(negedge clk); chk("basic_t1_log", bus.out_log, 17'h1F000); chk("basic_t1_sign", bus.out_sign, 1'b1);
        chk("basic_t1_idx", bus.out_idx, 2'd1);
        @(negedge clk); chk("basic_t2_log", bus.out_log, 17'h00100); chk("basic_t2_last", bus.out_last, 1'b1);
        chk("basic_t2_zero", bus.out_zero, 1'b0);
        @(negedge clk); chk("basic_ready_back", bus.in_ready, 1'b1); chk("basic_done_nv", bus.out_valid, 1'b0);

        // Zero input with invalid first log
        drive_edge();
        bus.in_x = 16'h0000; bus.in_valid = 1'b1; bus.map_valid_packed = 3'b110;
        drive_edge(); bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("zero_t0", bus.out_zero, 1'b1);
        @(negedge clk); chk("zero_t1", bus.out_zero, 1'b0);
        @(negedge clk); chk("zero_t2", bus.out_zero, 1'b0);

        // Backpressure at idx 1 for four cycles
        drive_edge();
        bus.in_x = 16'h0123; bus.in_valid = 1'b1; bus.map_valid_packed = 3'b111;
        bus.map_log_packed = {17'h0AAAA, 17'h15555, 17'h00ABC};
        drive_edge(); bus.in_valid = 1'b0;
        drive_edge();
        drive_edge(); bus.out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk); chk("bp_hold_idx", bus.out_idx, 2'd1); chk("bp_hold_log", bus.out_log, 17'h15555);
            drive_edge();
        end
        bus.out_ready = 1'b1;
        @(negedge clk); chk("bp_fifth_idx", bus.out_idx, 2'd1);
        @(negedge clk); chk("bp_next_idx", bus.out_idx, 2'd2); chk("bp_next_log", bus.out_log, 17'h0AAAA);
        @(negedge clk); chk("bp_done_ready", bus.in_ready, 1'b1);

        // Input stall: second sample waits for IDLE
        drive_edge();
        bus.in_x = 16'h2222; bus.in_valid = 1'b1;
        drive_edge(); bus.in_x = 16'h3333;
        repeat (4) begin
            @(negedge clk); chk("stall_ready", bus.in_ready, 1'b0); chk("stall_map_x", bus.map_x, 16'h2222);
        end
        @(negedge clk); chk("stall_idle_ready", bus.in_ready, 1'b1);
        drive_edge(); bus.in_valid = 1'b0;
        @(negedge clk); chk("stall_new_map_x", bus.map_x, 16'h3333);
        repeat (5) drive_edge();

        // Reset at idx 1
        bus.in_x = 16'h0444; bus.in_valid = 1'b1;
        drive_edge(); bus.in_valid = 1'b0;
        drive_edge();
        drive_edge(); reset = 1'b1;
        @(negedge clk); chk("rstmid_idx_before", bus.out_idx, 2'd1);
        drive_edge(); reset = 1'b0;
        @(negedge clk); chk("rstmid_nv", bus.out_valid, 1'b0); chk("rstmid_busy", bus.busy, 1'b0);
        chk("rstmid_ready", bus.in_ready, 1'b1);
        drive_edge(); bus.in_x = 16'h0555; bus.in_valid = 1'b1;
        drive_edge(); bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("rstmid_restart_idx", bus.out_idx, 2'd0); chk("rstmid_restart_v", bus.out_valid, 1'b1);
        repeat (4) drive_edge();

        // Map isolation: toggle map_* during EMIT
        bus.in_x = 16'h0777; bus.in_valid = 1'b1;
        bus.map_log_packed = {17'h00003, 17'h00002, 17'h00001}; bus.map_sign_packed = 3'b101;
        drive_edge(); bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_edge();
            bus.map_log_packed = ~bus.map_log_packed; bus.map_sign_packed = ~bus.map_sign_packed;
            @(negedge clk);
            chk("iso_log", bus.out_log, 17'(i + 1));
            chk("iso_sign", bus.out_sign, (i != 1));
        end
        repeat (2) drive_edge();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            drive_edge();
            reset = ($urandom_range(0, 79) == 0);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_x = W'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.map_log_packed = (Q*LW)'({$urandom, $urandom});
            bus.map_sign_packed = Q'($urandom);
            bus.map_valid_packed = Q'($urandom);
        end
        drive_edge(); reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/phimap_term_sequencer.md
PHIMAP_TERM_SEQUENCER -- requirements
Module: phimap_term_sequencer

Interface
REQ-001 SHALL have parameter Q_ORD, default 3, number of phi-map terms per sample.
REQ-002 SHALL have parameter WIDTH, default 16, input sample width (signed, QP=12).
REQ-003 SHALL have parameter LOG_WIDTH, default 17, log-domain term width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_x  input  WIDTH  signed sample.
REQ-007 SHALL have port in_valid / in_ready  input / output  1 each  sample handshake.
REQ-008 SHALL have port map_x  output  WIDTH  sample driven to the combinational phi-map datapath.
REQ-009 SHALL have port map_log_packed  input  Q_ORD*LOG_WIDTH  packed log terms returned by the phi-map (term k at bits [k*LOG_WIDTH +: LOG_WIDTH]).
REQ-010 SHALL have ports map_sign_packed, map_valid_packed  input  Q_ORD each  per-term sign and log-valid flags.
REQ-011 SHALL have port out_log  output  LOG_WIDTH  current serialized term.
REQ-012 SHALL have ports out_sign, out_zero, out_last  output  1 each  term sign; term is zero (log invalid); final term of sample.
REQ-013 SHALL have port out_idx  output  clog2(Q_ORD) (min 1)  term index.
REQ-014 SHALL have port out_valid / out_ready  output / input  1 each  term handshake.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, MAP, EMIT.
REQ-017 IDLE: in_ready=1, out_valid=0; on in_valid=1 latch in_x into x_reg, go MAP.
REQ-018 MAP (exactly 1 cycle): map_x=x_reg; at end of cycle capture map_log_packed, map_sign_packed, map_valid_packed into term registers, idx<=0, go EMIT.
REQ-019 map_x SHALL equal x_reg in all states (holds last sample; 0 after reset).
REQ-020 EMIT: out_valid=1, out_log/out_sign from term register idx, out_zero = ~map_valid[idx] as captured, out_idx=idx, out_last=(idx==Q_ORD-1).
REQ-021 EMIT with out_ready=0: all out_* SHALL remain stable; no state change.
REQ-022 EMIT with out_ready=1 and idx<Q_ORD-1: idx<=idx+1, stay EMIT.
REQ-023 EMIT with out_ready=1 and idx==Q_ORD-1: idx<=0, go IDLE.
REQ-024 in_ready SHALL be 0 in MAP and EMIT; in_valid there SHALL be ignored (sample held by upstream).
REQ-025 Latency: first term out_valid SHALL assert 2 cycles after the accepting in_valid&in_ready edge; minimum period Q_ORD+2 cycles per sample with out_ready held 1.
REQ-026 Changes on map_* inputs outside the MAP cycle SHALL NOT affect outputs.
REQ-027 out_log SHALL be passed unmodified (no rounding/saturation); out_zero is flag only.
REQ-028 When out_valid=0, out_log, out_sign, out_zero, out_last, out_idx SHALL be 0.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, idx=0, x_reg=0, term registers=0 regardless of state or pending handshakes; one cycle after release in_ready=1, out_valid=0, busy=0.
REQ-030 reset asserted mid-EMIT SHALL discard remaining terms; no out_valid in the cycle after reset.

Verification
REQ-031 Basic: Q_ORD=3, in_x=16'h1000, phi-map model returns logs {17'h00010,17'h1F000,17'h00100}, signs 3'b010, valid 3'b111, out_ready=1 -> terms idx 0,1,2 on cycles +2,+3,+4 with those logs, signs 0,1,0, out_zero 0, out_last only at idx 2; in_ready back at +5.
REQ-032 Zero input: in_x=0, map_valid_packed=3'b110 -> idx0 out_zero=1, idx1/2 out_zero=0.
REQ-033 Backpressure: out_ready=0 for 4 cycles at idx 1 -> idx1 data stable 5 cycles, then idx2, no term lost or repeated.
REQ-034 Input stall: in_valid held high with new in_x during EMIT -> in_ready=0, second sample accepted only in IDLE, map_x updates then.
REQ-035 Reset mid-operation: reset pulse at idx 1 -> next cycle out_valid=0, busy=0, in_ready=1; following sample sequences from idx 0.
REQ-036 Map isolation: toggle map_log_packed every cycle during EMIT -> outputs match values sampled in MAP cycle.
